// File: rtl/kronos_seg7_scan.sv
// Bus-mapped N-digit multiplexed seven-segment scanner with per-digit blanking.
// Define KRONOS_SEG7_DIM_EN to add the BRIGHT register (0xC) and PWM gating of cat.
`timescale 1ns/1ps

module kronos_seg7_scan #(
    parameter int NUM_DIGITS  = 2,
    parameter int REFRESH_DIV = 1024,
    parameter bit SEG_INVERT  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            data_addr,
    input  logic [31:0]           data_wdata,
    input  logic [3:0]            data_mask,
    input  logic                  data_wr_en,
    input  logic                  data_req,
    output logic                  data_ack,
    output logic [31:0]           data_rdata,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] cat
);

    localparam int DW = NUM_DIGITS * 4;
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0]         PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_IDLE   = SEG_INVERT ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] CAT_IDLE   = SEG_INVERT ? {NUM_DIGITS{1'b1}} : '0;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [DW-1:0]         data_q, data_d;
    logic                  en_q, en_d;
    logic [NUM_DIGITS-1:0] blank_q, blank_d;
    logic                  ack_q, ack_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] cat_q, cat_d;
`ifdef KRONOS_SEG7_DIM_EN
    logic [3:0]            bright_q, bright_d;
`endif

    logic [31:0]           rd_val;
    logic [31:0]           data_cur;
    logic [31:0]           data_merged;
    logic                  wr_commit;
    logic [3:0]            nibble;
    logic                  cat_on;
    logic [NUM_DIGITS-1:0] cat_raw;
    logic                  unused_bits;

    assign unused_bits = ^{data_addr[1:0], data_merged};

    always_comb begin
        ack_d     = data_req & ~ack_q;
        wr_commit = ack_d & data_wr_en;

        rd_val = '0;
        case (data_addr[3:2])
            2'd0: rd_val[DW-1:0] = data_q;
            2'd1: begin
                rd_val[0]               = en_q;
                rd_val[8 +: NUM_DIGITS] = blank_q;
            end
`ifdef KRONOS_SEG7_DIM_EN
            2'd3: rd_val[3:0] = bright_q;
`endif
            default: rd_val = '0;
        endcase
        rdata_d = (ack_d && !data_wr_en) ? rd_val : '0;

        data_cur         = '0;
        data_cur[DW-1:0] = data_q;
        for (int b = 0; b < 4; b++) begin
            data_merged[8*b +: 8] = data_mask[b] ? data_wdata[8*b +: 8] : data_cur[8*b +: 8];
        end

        data_d  = data_q;
        en_d    = en_q;
        blank_d = blank_q;
`ifdef KRONOS_SEG7_DIM_EN
        bright_d = bright_q;
`endif
        if (wr_commit) begin
            case (data_addr[3:2])
                2'd0: data_d = data_merged[DW-1:0];
                2'd1: begin
                    if (data_mask[0]) en_d    = data_wdata[0];
                    if (data_mask[1]) blank_d = data_wdata[8 +: NUM_DIGITS];
                end
`ifdef KRONOS_SEG7_DIM_EN
                2'd3: if (data_mask[0]) bright_d = data_wdata[3:0];
`endif
                default: ;
            endcase
        end
    end

    // Scan: prescaler wraps naturally since REFRESH_DIV is a power of two.
    always_comb begin
        presc_d = '0;
        idx_d   = '0;
        if (en_q) begin
            presc_d = presc_q + 1'b1;
            idx_d   = idx_q;
            if (presc_q == PRESC_LAST) begin
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end
        end

        nibble = data_q[idx_q*4 +: 4];
        cat_on = en_q && (presc_q != '0) && !blank_q[idx_q];
`ifdef KRONOS_SEG7_DIM_EN
        cat_on = cat_on && (presc_q[PW-1 -: 4] <= bright_q);
`endif
        cat_raw = '0;
        if (cat_on) cat_raw[idx_q] = 1'b1;

        seg_d = (en_q ? hex_decode(nibble) : 7'h00) ^ SEG_IDLE;
        cat_d = cat_raw ^ CAT_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            en_q    <= 1'b0;
            blank_q <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_IDLE;
            cat_q   <= CAT_IDLE;
`ifdef KRONOS_SEG7_DIM_EN
            bright_q <= 4'hF;
`endif
        end else begin
            data_q  <= data_d;
            en_q    <= en_d;
            blank_q <= blank_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            cat_q   <= cat_d;
`ifdef KRONOS_SEG7_DIM_EN
            bright_q <= bright_d;
`endif
        end
    end

    assign data_ack   = ack_q;
    assign data_rdata = rdata_q;
    assign seg        = seg_q;
    assign cat        = cat_q;

endmodule
